// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 single-bit mux between four requesters.
// Grants are registered one-hot with a bounded hold time under contention.

// 2:1 single-bit mux leaf.
module mux2x1 (
    input  logic a,
    input  logic b,
    input  logic s,
    output logic y
);
    assign y = s ? b : a;
endmodule

// 4:1 single-bit mux built as a tree of 2:1 muxes.
module mux4x1 (
    input  logic [3:0] d,
    input  logic [1:0] sel,
    output logic       y
);
    logic lo;
    logic hi;

    mux2x1 u_lo  (.a(d[0]), .b(d[1]), .s(sel[0]), .y(lo));
    mux2x1 u_hi  (.a(d[2]), .b(d[3]), .s(sel[0]), .y(hi));
    mux2x1 u_top (.a(lo),   .b(hi),   .s(sel[1]), .y(y));
endmodule

module mux4_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] d,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       y_valid,
    output logic       y
);
    localparam int unsigned N  = 4;
    localparam int unsigned SW = 2;
    localparam int unsigned CW = 4;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [SW-1:0]   ptr;
    logic [SW-1:0]   ptr_nxt;
    logic [CW-1:0]   hold_cnt;
    logic [CW-1:0]   hold_nxt;
    logic [N-1:0]    gnt_nxt;
    logic [SW-1:0]   sel_nxt;
    logic            y_valid_nxt;

    logic [SW-1:0]   winner;
    logic [SW-1:0]   scan_idx;
    logic            win_found;
    logic            req_any;
    logic            owner_req;
    logic            others_req;
    logic            hold_sat;
    logic            take_new;
    logic            mux_y;

    assign req_any    = |req;
    assign owner_req  = req[sel];
    assign others_req = |(req & ~gnt);
    assign hold_sat   = (hold_cnt >= CW'(MAX_HOLD));

    // Find the first asserted request scanning upward from ptr, wrapping mod 4.
    always_comb begin
        win_found = 1'b0;
        winner    = ptr;
        scan_idx  = ptr;
        for (int i = 0; i < int'(N); i++) begin
            scan_idx = ptr + SW'(i);
            if (!win_found && req[scan_idx]) begin
                win_found = 1'b1;
                winner    = scan_idx;
            end
        end
    end

    // Next-state and next-output decode: idle, hold, release or preempt.
    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        hold_nxt    = hold_cnt;
        gnt_nxt     = gnt;
        sel_nxt     = sel;
        y_valid_nxt = y_valid;
        take_new    = 1'b0;

        case (state)
            IDLE: begin
                if (req_any) begin
                    take_new = 1'b1;
                end
            end
            GRANT: begin
                if (!owner_req) begin
                    if (req_any) begin
                        take_new = 1'b1;
                    end else begin
                        state_nxt   = IDLE;
                        gnt_nxt     = '0;
                        y_valid_nxt = 1'b0;
                        hold_nxt    = '0;
                    end
                end else if (hold_sat && others_req) begin
                    take_new = 1'b1;
                end else if (!hold_sat) begin
                    hold_nxt = hold_cnt + CW'(1);
                end
            end
            default: begin
                state_nxt   = IDLE;
                gnt_nxt     = '0;
                y_valid_nxt = 1'b0;
                hold_nxt    = '0;
            end
        endcase

        // The owner sits at lowest priority after a grant since ptr moves past it.
        if (take_new) begin
            state_nxt   = GRANT;
            gnt_nxt     = N'(1) << winner;
            sel_nxt     = winner;
            y_valid_nxt = 1'b1;
            hold_nxt    = CW'(1);
            ptr_nxt     = winner + SW'(1);
        end
    end

    // State, pointer, hold counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            gnt      <= '0;
            sel      <= '0;
            y_valid  <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= hold_nxt;
            gnt      <= gnt_nxt;
            sel      <= sel_nxt;
            y_valid  <= y_valid_nxt;
        end
    end

    mux4x1 u_mux (.d(d), .sel(sel), .y(mux_y));

    // Output is gated so the shared path reads 0 when nobody owns it.
    assign y = y_valid & mux_y;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter with MAX_HOLD = 4.
module tb_mux4_rr_arbiter;
    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] d;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       y_valid;
    logic       y;

    int vectors;
    int miscompares;

    mux4_rr_arbiter #(.MAX_HOLD(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .d       (d),
        .gnt     (gnt),
        .sel     (sel),
        .y_valid (y_valid),
        .y       (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Async reset pulse placed between edges.
    task automatic pulse_reset;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req   = 4'b1111;
        d     = 4'b1111;
        #3;
        tick;
        tick;
        vectors++;
        if (gnt !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_gnt: got %b want 0000", gnt);
        end
        vectors++;
        if (sel !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_sel: got %b want 00", sel);
        end
        vectors++;
        if (y_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_y_valid: got %b want 0", y_valid);
        end
        vectors++;
        if (y !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_y: got %b want 0", y);
        end
        rst_n = 1'b1;
        tick;
        vectors++;
        if (gnt !== 4'b0001) begin
            miscompares++;
            $display("FAIL reset_first_grant: got %b want 0001", gnt);
        end
        req = 4'b0000;
        tick;
    endtask

    task automatic test_single;
        req = 4'b0000;
        tick;
        req = 4'b0100;
        d   = 4'b0100;
        tick;
        vectors++;
        if (gnt !== 4'b0100) begin
            miscompares++;
            $display("FAIL single_gnt: got %b want 0100", gnt);
        end
        vectors++;
        if (sel !== 2'b10) begin
            miscompares++;
            $display("FAIL single_sel: got %b want 10", sel);
        end
        vectors++;
        if (y !== 1'b1) begin
            miscompares++;
            $display("FAIL single_y_high: got %b want 1", y);
        end
        d = 4'b0000;
        #1;
        vectors++;
        if (y !== 1'b0) begin
            miscompares++;
            $display("FAIL single_y_comb: got %b want 0", y);
        end
        req = 4'b0000;
        tick;
        vectors++;
        if (gnt !== 4'b0000 || y_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_release: got gnt=%b y_valid=%b want 0000/0", gnt, y_valid);
        end
        vectors++;
        if (sel !== 2'b10) begin
            miscompares++;
            $display("FAIL single_sel_hold: got %b want 10", sel);
        end
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_gnt;
        logic [1:0] exp_idx;
        logic [3:0] dpat;
        dpat = 4'b1010;
        req  = 4'b1111;
        d    = dpat;
        pulse_reset;
        for (int c = 0; c < 20; c++) begin
            tick;
            exp_idx = 2'((c / 4) % 4);
            exp_gnt = 4'b0001 << exp_idx;
            vectors++;
            if (gnt !== exp_gnt || sel !== exp_idx || y_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL rr_cycle%0d: got gnt=%b sel=%0d v=%b want gnt=%b sel=%0d v=1",
                         c, gnt, sel, y_valid, exp_gnt, exp_idx);
            end
            vectors++;
            if (y !== dpat[exp_idx]) begin
                miscompares++;
                $display("FAIL rr_y%0d: got %b want %b", c, y, dpat[exp_idx]);
            end
        end
    endtask

    task automatic test_handoff;
        req = 4'b0011;
        d   = 4'b0010;
        pulse_reset;
        tick;
        vectors++;
        if (gnt !== 4'b0001 || y !== 1'b0) begin
            miscompares++;
            $display("FAIL handoff_first: got gnt=%b y=%b want 0001/0", gnt, y);
        end
        req = 4'b0010;
        tick;
        vectors++;
        if (gnt !== 4'b0010 || y_valid !== 1'b1 || y !== 1'b1) begin
            miscompares++;
            $display("FAIL handoff_next: got gnt=%b v=%b y=%b want 0010/1/1", gnt, y_valid, y);
        end
    endtask

    task automatic test_lone_then_contention;
        req = 4'b0010;
        pulse_reset;
        for (int c = 0; c < 10; c++) begin
            tick;
            vectors++;
            if (gnt !== 4'b0010) begin
                miscompares++;
                $display("FAIL lone_cycle%0d: got %b want 0010", c, gnt);
            end
        end
        req = 4'b0011;
        tick;
        vectors++;
        if (gnt !== 4'b0001 || sel !== 2'b00) begin
            miscompares++;
            $display("FAIL lone_preempt: got gnt=%b sel=%b want 0001/00", gnt, sel);
        end
    endtask

    task automatic test_async_reset;
        req = 4'b1000;
        d   = 4'b1111;
        pulse_reset;
        tick;
        vectors++;
        if (gnt !== 4'b1000) begin
            miscompares++;
            $display("FAIL areset_pre: got %b want 1000", gnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (gnt !== 4'b0000 || y_valid !== 1'b0 || sel !== 2'b00 || y !== 1'b0) begin
            miscompares++;
            $display("FAIL areset_clear: got gnt=%b v=%b sel=%b y=%b want 0000/0/00/0",
                     gnt, y_valid, sel, y);
        end
        req = 4'b1001;
        #2;
        rst_n = 1'b1;
        tick;
        vectors++;
        if (gnt !== 4'b0001) begin
            miscompares++;
            $display("FAIL areset_ptr: got %b want 0001", gnt);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        req         = 4'b0000;
        d           = 4'b0000;
        test_reset;
        test_single;
        test_round_robin;
        test_handoff;
        test_lone_then_contention;
        test_async_reset;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
